// File: rtl/m_fu_pkg.sv
// Shared definitions for the m_fu multi-precision multiplier: precision
// select encoding and per-precision lane widths.
package mfu_pkg;

   typedef enum logic [1:0] {
      MFU_NOOP = 2'b00,
      MFU_8B   = 2'b01,
      MFU_4B   = 2'b10,
      MFU_2B   = 2'b11
   } mfu_mode_e;

   localparam int LANE_8B_W = 16;
   localparam int LANE_4B_W = 8;
   localparam int LANE_2B_W = 4;

endpackage

// File: rtl/m_fu_bit_brick.sv
// 2x2 multiplier brick. Each operand slice is sign-extended only when its
// signed-enable is set; the 4-bit result is the product modulo 16.
module bit_brick (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       a_signed,
   input  logic       b_signed,
   output logic [3:0] prod
);

   logic [3:0] a_ext;
   logic [3:0] b_ext;

   // Every brick product (-6..9) is recoverable from 4 bits once the caller
   // knows whether either slice was signed.
   always_comb begin
      a_ext = {{2{a_signed & a[1]}}, a};
      b_ext = {{2{b_signed & b[1]}}, b};
      prod  = a_ext * b_ext;
   end

endmodule

// File: rtl/m_fu.sv
// Multi-precision signed multiplier built from 16 2x2 bricks (8x8, 2x 4x4, 4x 2x2).
// Define MFU_INPUT_REG_EN to register a/b/mode ahead of the brick array (2-cycle latency).
module m_fu
   import mfu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic [1:0]  mode,
   output logic [15:0] p
);

   logic [7:0]           a_q;
   logic [7:0]           b_q;
   mfu_mode_e            mode_q;
   logic [3:0]           sgn;
   logic [LANE_2B_W-1:0] prod [4][4];
   logic [LANE_8B_W-1:0] ext  [4][4];
   logic [LANE_8B_W-1:0] sum_8b;
   logic [LANE_4B_W-1:0] sum_4b [2];
   logic [15:0]          p_next;

`ifdef MFU_INPUT_REG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         mode_q <= MFU_NOOP;
      end else begin
         a_q    <= a;
         b_q    <= b;
         mode_q <= mfu_mode_e'(mode);
      end
   end
`else
   assign a_q    = a;
   assign b_q    = b;
   assign mode_q = mfu_mode_e'(mode);
`endif

   // A slice is signed only when it is the top slice of its lane.
   always_comb begin
      case (mode_q)
         MFU_8B:  sgn = 4'b1000;
         MFU_4B:  sgn = 4'b1010;
         MFU_2B:  sgn = 4'b1111;
         default: sgn = 4'b0000;
      endcase
   end

   for (genvar i = 0; i < 4; i++) begin : g_row
      for (genvar j = 0; j < 4; j++) begin : g_col
         bit_brick u_brick (
            .a        (a_q[2*i +: 2]),
            .b        (b_q[2*j +: 2]),
            .a_signed (sgn[i]),
            .b_signed (sgn[j]),
            .prod     (prod[i][j])
         );
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (sgn[i] | sgn[j]) begin
               ext[i][j] = {{(LANE_8B_W-4){prod[i][j][3]}}, prod[i][j]};
            end else begin
               ext[i][j] = {{(LANE_8B_W-4){1'b0}}, prod[i][j]};
            end
         end
      end
   end

   // Lane sums wrap at the lane width, so nothing can leak into a neighbour.
   always_comb begin
      sum_8b    = '0;
      sum_4b[0] = '0;
      sum_4b[1] = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            sum_8b = sum_8b + (ext[i][j] << (2*(i+j)));
         end
      end
      for (int h = 0; h < 2; h++) begin
         for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
               sum_4b[h] = sum_4b[h] +
                  (ext[2*h+i][2*h+j][LANE_4B_W-1:0] << (2*(i+j)));
            end
         end
      end
   end

   always_comb begin
      case (mode_q)
         MFU_8B:  p_next = sum_8b;
         MFU_4B:  p_next = {sum_4b[1], sum_4b[0]};
         MFU_2B:  p_next = {prod[3][3], prod[2][2], prod[1][1], prod[0][0]};
         default: p_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p <= '0;
      end else begin
         p <= p_next;
      end
   end

endmodule

// File: tb/tb_m_fu.sv
// Self-checking bench for m_fu: directed cases plus randomized vectors checked
// against an arithmetic reference model. Honours MFU_INPUT_REG_EN latency.
module tb_m_fu;

`ifdef MFU_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [1:0]  mode;
   logic [15:0] p;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] exp_q [$];
   string       tag_q [$];

   always #5 clk = ~clk;

   m_fu dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .mode (mode),
      .p    (p)
   );

   // Reference: slice each operand into lanes, multiply as integers, truncate to lane width.
   function automatic logic [15:0] refModel(input logic [7:0] x, input logic [7:0] y,
                                            input logic [1:0] m);
      logic [15:0] r;
      int          pa;
      int          pb;
      int          pr;
      r = '0;
      case (m)
         2'b01: begin
            pa = int'($signed(x));
            pb = int'($signed(y));
            pr = pa * pb;
            r  = pr[15:0];
         end
         2'b10: begin
            for (int k = 0; k < 2; k++) begin
               pa = int'($signed(x[4*k +: 4]));
               pb = int'($signed(y[4*k +: 4]));
               pr = pa * pb;
               r[8*k +: 8] = pr[7:0];
            end
         end
         2'b11: begin
            for (int k = 0; k < 4; k++) begin
               pa = int'($signed(x[2*k +: 2]));
               pb = int'($signed(y[2*k +: 2]));
               pr = pa * pb;
               r[4*k +: 4] = pr[3:0];
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] expv);
      vectors++;
      assert (p === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s got=%h exp=%h", tag, p, expv);
      end
   endtask

   // After reset the pipeline holds zeros, so the first LAT-1 results are 0.
   task automatic primeQueue();
      exp_q.delete();
      tag_q.delete();
      for (int k = 0; k < LAT - 1; k++) begin
         exp_q.push_back(16'h0000);
         tag_q.push_back("pipe_fill");
      end
   endtask

   task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                                input logic [1:0] m, input logic [15:0] expv,
                                input string tag);
      a    = x;
      b    = y;
      mode = m;
      exp_q.push_back(expv);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      checkOutput(tag_q.pop_front(), exp_q.pop_front());
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [1:0] rm;

      rst  = 1'b1;
      a    = 8'hFF;
      b    = 8'hFF;
      mode = 2'b01;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_hold", 16'h0000);
      rst = 1'b0;
      primeQueue();
      applyStimulus(8'hFF, 8'hFF, 2'b01, 16'h0001, "reset_release");

      applyStimulus(8'h81, 8'h05, 2'b01, 16'hFD85, "m8_neg127x5");
      applyStimulus(8'h80, 8'h80, 2'b01, 16'h4000, "m8_min_x_min");
      applyStimulus(8'h7F, 8'h3F, 2'b10, 16'h1501, "m4_7f_3f");
      applyStimulus(8'h88, 8'h88, 2'b10, 16'h4040, "m4_min_x_min");
      applyStimulus(8'hAA, 8'hAA, 2'b11, 16'h4444, "m2_min_x_min");
      applyStimulus(8'hE4, 8'h55, 2'b11, 16'hFE10, "m2_e4_55");

      applyStimulus(8'h7F, 8'h7F, 2'b01, 16'h3F01, "b2b_m8");
      applyStimulus(8'h7F, 8'h7F, 2'b10, 16'h3101, "b2b_m4");
      applyStimulus(8'h7F, 8'h7F, 2'b11, 16'h1111, "b2b_m2");
      applyStimulus(8'h7F, 8'h7F, 2'b00, 16'h0000, "b2b_noop");
      applyStimulus(8'h00, 8'h00, 2'b00, 16'h0000, "b2b_idle");

      applyStimulus(8'h81, 8'h05, 2'b01, 16'hFD85, "pre_reset");
      rst  = 1'b1;
      a    = 8'h7F;
      b    = 8'h3F;
      mode = 2'b10;
      @(posedge clk);
      #1;
      checkOutput("mid_reset", 16'h0000);
      rst = 1'b0;
      primeQueue();
      applyStimulus(8'h88, 8'h88, 2'b10, 16'h4040, "after_reset");

      for (int n = 0; n < 300; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rm = 2'($urandom_range(0, 3));
         applyStimulus(ra, rb, rm, refModel(ra, rb, rm), "random");
      end

      for (int n = 0; n < LAT; n++) begin
         applyStimulus(8'h00, 8'h00, 2'b00, 16'h0000, "drain");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
